// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, operand layout and flag constants for the FPU front end
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_MIN = 3'd3,
    OP_MAX = 3'd4,
    OP_NEG = 3'd5,
    OP_ABS = 3'd6,
    OP_RSV = 3'd7
  } fpu_op_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == 8'hFF) && (x.man != 23'd0);
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - binary32 adder, subnormals flushed to zero, result truncated
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic [31:0]        x, y;
  logic [26:0]        mx, my, my_sh;
  logic [27:0]        sum;
  logic [7:0]         d;
  logic signed [9:0]  e;
  logic [4:0]         lz;
  logic               found;
  logic               a_nan, b_nan, a_inf, b_inf;

  // align the smaller-magnitude operand, add or subtract, renormalise
  always_comb begin
    result    = 32'd0;
    overflow  = 1'b0;
    underflow = 1'b0;
    sum       = 28'd0;
    lz        = 5'd0;
    found     = 1'b0;
    a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf     = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf     = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    x = a;
    y = b;
    if (b[30:0] > a[30:0]) begin
      x = b;
      y = a;
    end
    mx    = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    my    = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    d     = x[30:23] - y[30:23];
    my_sh = (d > 8'd26) ? 27'd0 : (my >> d);
    e     = $signed({2'b00, x[30:23]});
    if (a_nan || b_nan) begin
      result = 32'h7FC00000;
    end else if (a_inf && b_inf && (a[31] != b[31])) begin
      result = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      result = x;
    end else if (x[30:23] == 8'd0) begin
      result = {x[31] & y[31], 31'd0};
    end else begin
      if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, my_sh};
      else                sum = {1'b0, mx} - {1'b0, my_sh};
      if (sum != 28'd0) begin
        if (sum[27]) begin
          sum = sum >> 1;
          e   = e + 10'sd1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found) begin
              if (sum[i]) found = 1'b1;
              else        lz    = lz + 5'd1;
            end
          end
          sum = sum << lz;
          e   = e - $signed({5'd0, lz});
        end
        if (e >= 10'sd255) begin
          overflow = 1'b1;
          result   = {x[31], 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
          underflow = 1'b1;
          result    = {x[31], 31'd0};
        end else begin
          result = {x[31], e[7:0], sum[25:3]};
        end
      end
    end
  end

endmodule

// File: rtl/fpu_pipe_unit_minmax.sv
// rtl/fpu_pipe_unit_minmax.sv - IEEE-style min/max with -0 < +0 and NaN suppression
module fpu_minmax
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_max,
  output logic [31:0] result,
  output logic        invalid
);

  logic a_nan, b_nan, a_lt_b;

  // order the operands; a lone NaN yields the other operand, two NaNs yield the canonical NaN
  always_comb begin
    a_nan = is_nan(fp32_t'(a));
    b_nan = is_nan(fp32_t'(b));
    if (a[31] != b[31]) a_lt_b = a[31];
    else if (!a[31])    a_lt_b = (a[30:0] < b[30:0]);
    else                a_lt_b = (a[30:0] > b[30:0]);
    invalid = a_nan || b_nan;
    if (a_nan && b_nan) result = CANON_NAN;
    else if (a_nan)     result = b;
    else if (b_nan)     result = a;
    else if (is_max)    result = a_lt_b ? b : a;
    else                result = a_lt_b ? a : b;
  end

endmodule

// File: rtl/multiplication.sv
// rtl/multiplication.sv - binary32 multiplier, subnormals flushed to zero, round to nearest even
module multiplication (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic [47:0]       p;
  logic [46:0]       pn;
  logic [23:0]       mr;
  logic signed [9:0] e;
  logic              s, rnd, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // full 24x24 product, normalise by one bit, round, then classify the exponent
  always_comb begin
    result    = 32'd0;
    overflow  = 1'b0;
    underflow = 1'b0;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    p   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    pn  = p[47] ? p[46:0] : {p[45:0], 1'b0};
    if (p[47]) e = e + 10'sd1;
    rnd = pn[23] && ((pn[22:0] != 23'd0) || pn[24]);
    mr  = {1'b0, pn[46:24]} + {23'd0, rnd};
    if (mr[23]) e = e + 10'sd1;
    if (a_nan || b_nan) begin
      result = 32'h7FC00000;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      result = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      result = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      result = {s, 31'd0};
    end else if (e >= 10'sd255) begin
      overflow = 1'b1;
      result   = {s, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      underflow = 1'b1;
      result    = {s, 31'd0};
    end else begin
      result = {s, e[7:0], mr[22:0]};
    end
  end

endmodule

// File: rtl/fpu_pipe_unit.sv
// rtl/fpu_pipe_unit.sv - handshaked FPU front end with a stalling LAT-deep result pipeline
module fpu_pipe_unit
  import fpu_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags,
  output logic [2:0]       flags_sticky,
  input  logic             flags_clr,
  output logic             busy
);

  typedef struct packed {
    logic             valid;
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
  } stage_t;

  fpu_op_e     op;
  logic [31:0] add_b, add_res, mul_res, mm_res, c_result;
  logic        add_ovf, add_unf, mul_ovf, mul_unf, mm_inv;
  logic [2:0]  c_flags;
  logic        advance, out_hs;
  logic [LAT-1:0] stage_v;
  logic [2:0]  sticky_q, sticky_d;

  assign op    = fpu_op_e'(in_op);
  assign add_b = (op == OP_SUB) ? {~in_b[31], in_b[30:0]} : in_b;

  adder u_adder (
    .a(in_a), .b(add_b), .result(add_res), .overflow(add_ovf), .underflow(add_unf)
  );

  multiplication u_mul (
    .a(in_a), .b(in_b), .result(mul_res), .overflow(mul_ovf), .underflow(mul_unf)
  );

  fpu_minmax u_minmax (
    .a(in_a), .b(in_b), .is_max(op == OP_MAX), .result(mm_res), .invalid(mm_inv)
  );

  // select the result and exception flags of the offered operation
  always_comb begin
    c_result = CANON_NAN;
    c_flags  = 3'b000;
    case (op)
      OP_ADD, OP_SUB: begin
        c_result         = add_res;
        c_flags[FLG_OVF] = add_ovf;
        c_flags[FLG_UNF] = add_unf;
      end
      OP_MUL: begin
        c_result         = mul_res;
        c_flags[FLG_OVF] = mul_ovf;
        c_flags[FLG_UNF] = mul_unf;
      end
      OP_MIN, OP_MAX: begin
        c_result         = mm_res;
        c_flags[FLG_INV] = mm_inv;
      end
      OP_NEG:  c_result = {~in_a[31], in_a[30:0]};
      OP_ABS:  c_result = {1'b0, in_a[30:0]};
      default: begin
        c_result         = CANON_NAN;
        c_flags[FLG_INV] = 1'b1;
      end
    endcase
  end

  // the whole pipe moves as one; bubbles are kept so ordering and latency stay fixed
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar g = 0; g < LAT; g++) begin : g_stage
    stage_t st_d, st_q;
    if (g == 0) begin : g_head
      assign st_d = '{valid: in_valid, result: c_result, tag: in_tag, flags: c_flags};
    end else begin : g_body
      assign st_d = g_stage[g-1].st_q;
    end
    assign stage_v[g] = st_q.valid;

    // stage register: load from upstream on advance, hold otherwise
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)          st_q <= '0;
      else if (advance) st_q <= st_d;
    end
  end

  assign out_valid  = g_stage[LAT-1].st_q.valid;
  assign out_result = g_stage[LAT-1].st_q.result;
  assign out_tag    = g_stage[LAT-1].st_q.tag;
  assign out_flags  = g_stage[LAT-1].st_q.flags;
  assign busy       = |stage_v;
  assign out_hs     = out_valid && out_ready;

  assign sticky_d = (flags_clr ? 3'b000 : sticky_q) | (out_hs ? out_flags : 3'b000);

  // accumulate delivered flags; a flag arriving with a clear still lands
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sticky_q <= 3'b000;
    else     sticky_q <= sticky_d;
  end

  assign flags_sticky = sticky_q;

endmodule

// File: tb/tb_fpu_pipe_unit.sv
// tb/tb_fpu_pipe_unit.sv - directed scoreboard bench for fpu_pipe_unit
module tb_fpu_pipe_unit;

  localparam int LAT   = 2;
  localparam int TAG_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'd0;
  logic [31:0]      in_a = 32'd0;
  logic [31:0]      in_b = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;
  logic [2:0]       flags_sticky;
  logic             flags_clr = 1'b0;
  logic             busy;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flg;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pop_last = -1;
  int   pop_prev = -1;
  logic             hold_v = 1'b0;
  logic [31:0]      hold_res;
  logic [TAG_W-1:0] hold_tag;
  logic [2:0]       hold_flg;

  logic [2:0]  s_op  [6] = '{3'd5, 3'd6, 3'd0, 3'd2, 3'd3, 3'd1};
  logic [31:0] s_a   [6] = '{32'h3F800000, 32'hC0400000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000};
  logic [31:0] s_b   [6] = '{32'h0, 32'h0, 32'h3F800000, 32'h40000000, 32'hC0000000, 32'h40000000};
  logic [31:0] s_exp [6] = '{32'hBF800000, 32'h40400000, 32'h40000000, 32'h40800000, 32'hC0000000, 32'h00000000};

  fpu_pipe_unit #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output monitor: stability while stalled, scoreboard pop on handshake
  always @(negedge CLK) begin
    if (RST) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_result", out_result, hold_res);
        chk("stall_tag", out_tag, hold_tag);
        chk("stall_flags", out_flags, hold_flg);
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_result;
      hold_tag = out_tag;
      hold_flg = out_flags;
      if (out_valid && out_ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out: observed result=%h tag=%0d, expected no output", out_result, out_tag);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_tag", out_tag, e.tag);
          chk("out_flags", out_flags, e.flg);
          pop_prev = pop_last;
          pop_last = cyc;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] er, input logic [2:0] ef,
                      input bit track);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (in_ready) begin
        if (track) sb.push_back('{res: er, tag: tag, flg: ef});
        accepted = 1'b1;
        @(posedge CLK); #1;
        break;
      end
      @(posedge CLK); #1;
    end
    chk("send_accepted", accepted, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 50; n++) begin
      if (sb.size() == 0) break;
      @(posedge CLK); #1;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sticky", flags_sticky, 3'b000);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", out_flags, 3'b000);
    RST = 1'b0;
    @(posedge CLK); #1;

    send(3'd0, 32'h3F800000, 32'h40000000, 4'd5, 32'h40400000, 3'b000, 1'b1);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("add_lat_n1", out_valid, 1'b0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("add_lat_n2", out_valid, 1'b1);
    @(posedge CLK); #1;
    drain("add_drain");

    send(3'd1, 32'h40400000, 32'h3F800000, 4'd1, 32'h40000000, 3'b000, 1'b1);
    send(3'd2, 32'h40000000, 32'h40400000, 4'd2, 32'h40C00000, 3'b000, 1'b1);
    in_valid = 1'b0;
    drain("b2b_drain");
    chk("b2b_consecutive", pop_last - pop_prev, 1);

    send(3'd3, 32'h80000000, 32'h00000000, 4'd3, 32'h80000000, 3'b000, 1'b1);
    send(3'd4, 32'h7FC00001, 32'hC0000000, 4'd4, 32'hC0000000, 3'b100, 1'b1);
    send(3'd7, 32'h12345678, 32'h9ABCDEF0, 4'd6, 32'h7FC00000, 3'b100, 1'b1);
    in_valid = 1'b0;
    drain("misc_drain");
    chk("sticky_inv", flags_sticky, 3'b100);

    begin
      int k;
      k = 0;
      for (int c = 0; c < 40; c++) begin
        out_ready = !(c >= 2 && c < 7);
        in_valid  = (k < 6);
        if (k < 6) begin
          in_op  = s_op[k];
          in_a   = s_a[k];
          in_b   = s_b[k];
          in_tag = 4'(10 + k);
        end
        @(negedge CLK);
        if (!out_ready && out_valid) chk("stall_in_ready", in_ready, 1'b0);
        if (in_valid && in_ready) begin
          sb.push_back('{res: s_exp[k], tag: 4'(10 + k), flg: 3'b000});
          k++;
        end
        @(posedge CLK); #1;
        if (k == 6 && sb.size() == 0) break;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_sent", k, 6);
      drain("stream_drain");
    end

    flags_clr = 1'b1;
    @(posedge CLK); #1;
    flags_clr = 1'b0;
    chk("clr_idle", flags_sticky, 3'b000);
    send(3'd2, 32'h7F000000, 32'h7F000000, 4'd7, 32'h7F800000, 3'b010, 1'b1);
    in_valid = 1'b0;
    drain("ovf_drain");
    chk("sticky_ovf", flags_sticky, 3'b010);
    flags_clr = 1'b1;
    @(posedge CLK); #1;
    flags_clr = 1'b0;
    chk("clr_idle2", flags_sticky, 3'b000);
    send(3'd2, 32'h7F000000, 32'h7F000000, 4'd8, 32'h7F800000, 3'b010, 1'b1);
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin
        flags_clr = 1'b1;
        @(posedge CLK); #1;
        flags_clr = 1'b0;
        break;
      end
      @(posedge CLK); #1;
    end
    chk("set_wins_drain", sb.size(), 0);
    chk("set_wins", flags_sticky, 3'b010);

    out_ready = 1'b0;
    send(3'd0, 32'h3F800000, 32'h3F800000, 4'd9, 32'h0, 3'b000, 1'b0);
    send(3'd5, 32'h3F800000, 32'h0, 4'd10, 32'h0, 3'b000, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    RST = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sticky", flags_sticky, 3'b000);
    @(posedge CLK); #1;
    RST = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    repeat (10) @(posedge CLK);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
